// File: rtl/instruction_dispatcher.sv
// ---------------------------------------------------------------------------
// instruction_dispatcher
//   Pulls instructions from the instruction queue one at a time and issues
//   them to the weight loader, matmul and activation units. It enforces the
//   ordering hazards between the units and tracks per-unit busy state with a
//   start/done handshake.
//
// Ports
//   clk_i, rst_i         clock (rising edge), async active-low reset
//   enable_i             dispatch enable
//   iq_empty_i           queue empty
//   iq_read_o            queue read strobe; data is valid the following cycle
//   iq_instr_i           queue output word
//   wl_start_o/done_i    weight-loader handshake
//   mm_start_o/done_i    matmul handshake
//   act_start_o/done_i   activation handshake
//   operand_o            payload of the last issued instruction
//   halted_o             dispatcher halted by HALT
//   error_o              sticky illegal-opcode flag
//   issued_cnt_o         instructions retired from decode (wraps)
// ---------------------------------------------------------------------------
module instruction_dispatcher #(
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        enable_i,
  input  logic                        iq_empty_i,
  output logic                        iq_read_o,
  input  logic [INSTR_W-1:0]          iq_instr_i,
  output logic                        wl_start_o,
  input  logic                        wl_done_i,
  output logic                        mm_start_o,
  input  logic                        mm_done_i,
  output logic                        act_start_o,
  input  logic                        act_done_i,
  output logic [INSTR_W-OPCODE_W-1:0] operand_o,
  output logic                        halted_o,
  output logic                        error_o,
  output logic [CNT_W-1:0]            issued_cnt_o
);

  localparam int unsigned PAYLOAD_W = INSTR_W - OPCODE_W;

  localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_WL   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_MM   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ACT  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(15);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_ISSUE,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t                 r_state, w_state_d;
  logic [INSTR_W-1:0]     r_instr, w_instr_d;
  logic                   r_wl_busy, r_mm_busy, r_act_busy;
  logic                   w_wl_busy_d, w_mm_busy_d, w_act_busy_d;
  logic                   r_iq_read, w_iq_read_d;
  logic                   r_wl_start, r_mm_start, r_act_start;
  logic                   w_wl_start_d, w_mm_start_d, w_act_start_d;
  logic [PAYLOAD_W-1:0]   r_operand, w_operand_d;
  logic                   r_halted, w_halted_d;
  logic                   r_error, w_error_d;
  logic [CNT_W-1:0]       r_issued_cnt, w_issued_cnt_d;
  logic                   w_retire;

  logic [OPCODE_W-1:0]    w_opcode;
  logic [PAYLOAD_W-1:0]   w_payload;

  assign w_opcode  = r_instr[INSTR_W-1 -: OPCODE_W];
  assign w_payload = r_instr[PAYLOAD_W-1:0];

  // State and registered-output update
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_instr      <= '0;
      r_wl_busy    <= 1'b0;
      r_mm_busy    <= 1'b0;
      r_act_busy   <= 1'b0;
      r_iq_read    <= 1'b0;
      r_wl_start   <= 1'b0;
      r_mm_start   <= 1'b0;
      r_act_start  <= 1'b0;
      r_operand    <= '0;
      r_halted     <= 1'b0;
      r_error      <= 1'b0;
      r_issued_cnt <= '0;
    end else begin
      r_state      <= w_state_d;
      r_instr      <= w_instr_d;
      r_wl_busy    <= w_wl_busy_d;
      r_mm_busy    <= w_mm_busy_d;
      r_act_busy   <= w_act_busy_d;
      r_iq_read    <= w_iq_read_d;
      r_wl_start   <= w_wl_start_d;
      r_mm_start   <= w_mm_start_d;
      r_act_start  <= w_act_start_d;
      r_operand    <= w_operand_d;
      r_halted     <= w_halted_d;
      r_error      <= w_error_d;
      r_issued_cnt <= w_issued_cnt_d;
    end
  end

  // Next-state, decode and hazard resolution
  always_comb begin
    w_state_d     = r_state;
    w_instr_d     = r_instr;
    w_wl_start_d  = 1'b0;
    w_mm_start_d  = 1'b0;
    w_act_start_d = 1'b0;
    w_operand_d   = r_operand;
    w_halted_d    = r_halted;
    w_error_d     = r_error;
    w_retire      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (enable_i && !iq_empty_i) w_state_d = S_FETCH;
      end
      S_FETCH: begin
        w_state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_instr_d = iq_instr_i;
        w_state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // Hazards use the registered busy flags, so a done pulse in this
        // cycle releases the start one cycle later.
        case (w_opcode)
          OP_NOP: begin
            w_retire  = 1'b1;
            w_state_d = S_IDLE;
          end
          OP_WL: begin
            if (!r_wl_busy) begin
              w_wl_start_d = 1'b1;
              w_operand_d  = w_payload;
              w_retire     = 1'b1;
              w_state_d    = S_IDLE;
            end
          end
          OP_MM: begin
            // Weights must be fully resident before a matmul starts.
            if (!r_mm_busy && !r_wl_busy) begin
              w_mm_start_d = 1'b1;
              w_operand_d  = w_payload;
              w_retire     = 1'b1;
              w_state_d    = S_IDLE;
            end
          end
          OP_ACT: begin
            if (!r_act_busy && !r_mm_busy) begin
              w_act_start_d = 1'b1;
              w_operand_d   = w_payload;
              w_retire      = 1'b1;
              w_state_d     = S_IDLE;
            end
          end
          OP_HALT: begin
            w_state_d = S_DRAIN;
          end
          default: begin
            w_error_d = 1'b1;
            w_retire  = 1'b1;
            w_state_d = S_IDLE;
          end
        endcase
      end
      S_DRAIN: begin
        if (!r_wl_busy && !r_mm_busy && !r_act_busy) begin
          w_retire   = 1'b1;
          w_halted_d = 1'b1;
          w_state_d  = S_HALTED;
        end
      end
      S_HALTED: begin
        if (!enable_i) begin
          w_halted_d = 1'b0;
          w_state_d  = S_IDLE;
        end
      end
      default: begin
        w_state_d = S_IDLE;
      end
    endcase

    w_iq_read_d    = (w_state_d == S_FETCH);
    w_issued_cnt_d = w_retire ? r_issued_cnt + CNT_W'(1) : r_issued_cnt;

    // A start sets busy; done clears it; done on an idle unit is a no-op.
    w_wl_busy_d  = w_wl_start_d  | (r_wl_busy  & ~wl_done_i);
    w_mm_busy_d  = w_mm_start_d  | (r_mm_busy  & ~mm_done_i);
    w_act_busy_d = w_act_start_d | (r_act_busy & ~act_done_i);
  end

  assign iq_read_o    = r_iq_read;
  assign wl_start_o   = r_wl_start;
  assign mm_start_o   = r_mm_start;
  assign act_start_o  = r_act_start;
  assign operand_o    = r_operand;
  assign halted_o     = r_halted;
  assign error_o      = r_error;
  assign issued_cnt_o = r_issued_cnt;

endmodule

// File: tb/tb_instruction_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_instruction_dispatcher
//   Directed bench for instruction_dispatcher. A small queue model feeds
//   instructions, unit models return done pulses a set delay after each
//   start, and expected {unit, operand} issues are queued at push time and
//   consumed as start pulses appear.
// ---------------------------------------------------------------------------
module tb_instruction_dispatcher;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned PAY_W    = INSTR_W - OPCODE_W;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b0;
  logic               enable_i = 1'b0;
  logic               iq_empty_i = 1'b1;
  logic               iq_read_o;
  logic [INSTR_W-1:0] iq_instr_i = '0;
  logic               wl_start_o, mm_start_o, act_start_o;
  logic               wl_done_i = 1'b0, mm_done_i = 1'b0, act_done_i = 1'b0;
  logic [PAY_W-1:0]   operand_o;
  logic               halted_o, error_o;
  logic [CNT_W-1:0]   issued_cnt_o;

  instruction_dispatcher #(
    .INSTR_W (INSTR_W),
    .OPCODE_W(OPCODE_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .iq_empty_i  (iq_empty_i),
    .iq_read_o   (iq_read_o),
    .iq_instr_i  (iq_instr_i),
    .wl_start_o  (wl_start_o),
    .wl_done_i   (wl_done_i),
    .mm_start_o  (mm_start_o),
    .mm_done_i   (mm_done_i),
    .act_start_o (act_start_o),
    .act_done_i  (act_done_i),
    .operand_o   (operand_o),
    .halted_o    (halted_o),
    .error_o     (error_o),
    .issued_cnt_o(issued_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int               unit;
    logic [PAY_W-1:0] opnd;
  } exp_t;

  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;
  logic [INSTR_W-1:0] iq[$];
  exp_t             sb[$];
  int               dly[3];
  int               due[3];
  int               start_cyc[3];
  int               start_cnt[3];
  int               done_cyc[3];
  int               read_cnt = 0;
  int               read_cyc = 0;
  int               halt_cyc = 0;
  int               r0 = 0;
  int               s0 = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic on_start(input int u);
    exp_t e;
    start_cnt[u]++;
    start_cyc[u] = cyc;
    due[u] = cyc + dly[u];
    check("start_expected", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("start_unit", 64'(u), 64'(e.unit));
      check("start_operand", 64'(operand_o), 64'(e.opnd));
    end
  endtask

  // One clock; outputs observed and inputs updated on the falling edge.
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
    wl_done_i  = 1'b0;
    mm_done_i  = 1'b0;
    act_done_i = 1'b0;
    if (iq_read_o) begin
      read_cnt++;
      read_cyc = cyc;
      check("read_has_data", 64'(iq.size() != 0), 64'd1);
      if (iq.size() != 0) iq_instr_i = iq.pop_front();
    end
    iq_empty_i = (iq.size() == 0);
    if (wl_start_o)  on_start(0);
    if (mm_start_o)  on_start(1);
    if (act_start_o) on_start(2);
    if (due[0] == cyc) begin wl_done_i  = 1'b1; done_cyc[0] = cyc; end
    if (due[1] == cyc) begin mm_done_i  = 1'b1; done_cyc[1] = cyc; end
    if (due[2] == cyc) begin act_done_i = 1'b1; done_cyc[2] = cyc; end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [3:0] op, input logic [PAY_W-1:0] p);
    exp_t e;
    iq.push_back({op, p});
    iq_empty_i = 1'b0;
    if (op inside {4'd1, 4'd2, 4'd3}) begin
      e.unit = int'(op) - 1;
      e.opnd = p;
      sb.push_back(e);
    end
  endtask

  task automatic wait_start(input int u, input int budget);
    int c0 = start_cnt[u];
    int n  = 0;
    while (start_cnt[u] == c0 && n < budget) begin
      tick();
      n++;
    end
    check("wait_start", 64'(start_cnt[u] != c0), 64'd1);
  endtask

  function automatic int total_starts();
    return start_cnt[0] + start_cnt[1] + start_cnt[2];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int u = 0; u < 3; u++) begin
      dly[u] = 4; due[u] = -1; start_cyc[u] = 0; start_cnt[u] = 0; done_cyc[u] = 0;
    end

    // Reset state
    run(3);
    check("rst_iq_read",  64'(iq_read_o),    64'd0);
    check("rst_wl_start", 64'(wl_start_o),   64'd0);
    check("rst_mm_start", 64'(mm_start_o),   64'd0);
    check("rst_act_start",64'(act_start_o),  64'd0);
    check("rst_operand",  64'(operand_o),    64'd0);
    check("rst_halted",   64'(halted_o),     64'd0);
    check("rst_error",    64'(error_o),      64'd0);
    check("rst_cnt",      64'(issued_cnt_o), 64'd0);
    rst_i = 1'b1;
    run(2);

    // Single LOAD_WEIGHTS: read to start latency and single read strobe
    dly[0] = 5;
    enable_i = 1'b1;
    r0 = read_cnt;
    push(4'd1, 28'h10);
    wait_start(0, 20);
    check("t1_read_to_start", 64'(start_cyc[0] - read_cyc), 64'd3);
    check("t1_reads", 64'(read_cnt - r0), 64'd1);
    exp_cnt = exp_cnt + 1'b1;
    check("t1_cnt", 64'(issued_cnt_o), 64'(exp_cnt));
    run(10);

    // MATMUL blocked by a slow weight load
    dly[0] = 20; dly[1] = 4;
    push(4'd1, 28'h21);
    push(4'd2, 28'h22);
    wait_start(0, 20);
    wait_start(1, 40);
    check("t2_mm_after_wl_done", 64'((start_cyc[1] - done_cyc[0]) inside {[1:2]}), 64'd1);
    exp_cnt = exp_cnt + 2'd2;
    check("t2_cnt", 64'(issued_cnt_o), 64'(exp_cnt));
    run(10);

    // ACTIVATE held by busy matmul while LOAD_WEIGHTS proceeds
    dly[1] = 25; dly[0] = 3; dly[2] = 2;
    push(4'd2, 28'h31);
    push(4'd1, 28'h32);
    push(4'd3, 28'h33);
    wait_start(1, 20);
    wait_start(0, 20);
    check("t3_wl_unblocked", 64'(start_cyc[0] - start_cyc[1]), 64'd4);
    wait_start(2, 40);
    check("t3_act_after_mm_done", 64'((start_cyc[2] - done_cyc[1]) inside {[1:2]}), 64'd1);
    exp_cnt = exp_cnt + 2'd3;
    check("t3_cnt", 64'(issued_cnt_o), 64'(exp_cnt));
    run(10);

    // Illegal opcode then NOP
    s0 = total_starts();
    push(4'd7, 28'h41);
    push(4'd0, 28'h42);
    run(16);
    check("t4_error", 64'(error_o), 64'd1);
    exp_cnt = exp_cnt + 2'd2;
    check("t4_cnt", 64'(issued_cnt_o), 64'(exp_cnt));
    check("t4_no_starts", 64'(total_starts() - s0), 64'd0);
    run(5);
    check("t4_error_sticky", 64'(error_o), 64'd1);

    // Enable dropped after fetch: current instruction completes, no new fetch
    dly[0] = 3;
    r0 = read_cnt;
    push(4'd1, 28'h61);
    push(4'd0, 28'h62);
    for (int n = 0; n < 10 && read_cnt == r0; n++) tick();
    enable_i = 1'b0;
    wait_start(0, 10);
    run(12);
    check("t5_one_read", 64'(read_cnt - r0), 64'd1);
    exp_cnt = exp_cnt + 1'b1;
    check("t5_cnt_held", 64'(issued_cnt_o), 64'(exp_cnt));
    enable_i = 1'b1;
    run(12);
    check("t5_resume_read", 64'(read_cnt - r0), 64'd2);
    exp_cnt = exp_cnt + 1'b1;
    check("t5_cnt_resume", 64'(issued_cnt_o), 64'(exp_cnt));

    // HALT drains the busy weight loader first
    dly[0] = 15;
    push(4'd1, 28'h51);
    push(4'd15, 28'h0);
    wait_start(0, 10);
    for (int n = 0; n < 30 && !halted_o; n++) tick();
    halt_cyc = cyc;
    check("t6_halted", 64'(halted_o), 64'd1);
    check("t6_halt_after_done", 64'(halt_cyc > done_cyc[0]), 64'd1);
    exp_cnt = exp_cnt + 2'd2;
    check("t6_cnt", 64'(issued_cnt_o), 64'(exp_cnt));
    r0 = read_cnt;
    push(4'd0, 28'h52);
    run(6);
    check("t6_no_fetch_halted", 64'(read_cnt - r0), 64'd0);
    check("t6_halt_holds", 64'(halted_o), 64'd1);
    enable_i = 1'b0;
    run(2);
    check("t6_halt_release", 64'(halted_o), 64'd0);
    enable_i = 1'b1;
    run(8);
    check("t6_resume_read", 64'(read_cnt - r0), 64'd1);
    exp_cnt = exp_cnt + 1'b1;
    check("t6_resume_cnt", 64'(issued_cnt_o), 64'(exp_cnt));

    // Reset while ACTIVATE waits on a busy matmul
    dly[1] = 1000;
    push(4'd2, 28'h71);
    push(4'd3, 28'h72);
    wait_start(1, 10);
    run(6);
    rst_i = 1'b0;
    #1;
    check("t7_iq_read",  64'(iq_read_o),    64'd0);
    check("t7_act_start",64'(act_start_o),  64'd0);
    check("t7_operand",  64'(operand_o),    64'd0);
    check("t7_halted",   64'(halted_o),     64'd0);
    check("t7_error",    64'(error_o),      64'd0);
    check("t7_cnt",      64'(issued_cnt_o), 64'd0);
    sb.delete();
    iq.delete();
    iq_empty_i = 1'b1;
    for (int u = 0; u < 3; u++) due[u] = -1;
    exp_cnt = '0;
    run(2);
    rst_i = 1'b1;
    s0 = total_starts();
    run(20);
    check("t7_no_start", 64'(total_starts() - s0), 64'd0);
    check("t7_cnt_after", 64'(issued_cnt_o), 64'(exp_cnt));
    dly[2] = 2;
    push(4'd3, 28'h81);
    wait_start(2, 10);
    exp_cnt = exp_cnt + 1'b1;
    check("t7_act_after_reset_cnt", 64'(issued_cnt_o), 64'(exp_cnt));
    run(6);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
